// File: rtl/video_levels_pkg.sv
// Shared luma level definitions for the tape video transmit and receive paths:
// symbol code table, framing marker levels and the framer state encoding.
package video_levels_pkg;

    localparam int NUM_CODES = 12;

    localparam logic [7:0] IDLE_LVL  = 8'd16;
    localparam logic [7:0] BEGIN_LVL = 8'd190;
    localparam logic [7:0] END_LVL   = 8'd200;

    // Entry i of CODE_TABLE maps to entry i of LEVEL_TABLE; entry 0 is also the
    // level substituted for codes that are not in the table.
    localparam logic [3:0] CODE_TABLE [NUM_CODES] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
        4'b1100, 4'b1000, 4'b1001, 4'b0110, 4'b1010, 4'b0101
    };

    localparam logic [7:0] LEVEL_TABLE [NUM_CODES] = '{
        8'd70,  8'd80,  8'd90,  8'd100, 8'd110, 8'd120,
        8'd130, 8'd140, 8'd150, 8'd160, 8'd170, 8'd180
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEGIN = 2'd1,
        ST_DATA  = 2'd2,
        ST_END   = 2'd3
    } vo_state_t;

endpackage

// File: rtl/video_out_if.sv
// Symbol stream from the tape formatter and luma sample bus toward the encoder.
// master = symbol source / sample consumer side, slave = the video_out block.
interface video_out_if;

    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] td_out;
    logic       sample_strobe;
    logic       busy;
    logic       code_err;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  td_out,
        input  sample_strobe,
        input  busy,
        input  code_err
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output td_out,
        output sample_strobe,
        output busy,
        output code_err
    );

endinterface

// File: rtl/video_level_enc.sv
// Combinational symbol code to luma level lookup; unknown codes map to the
// first table level and raise the invalid flag.
module video_level_enc
    import video_levels_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] level,
    output logic       invalid
);

    logic [NUM_CODES-1:0] hit;
    logic [7:0]           masked [NUM_CODES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CODES; gi++) begin : g_entry
            assign hit[gi]    = (code == CODE_TABLE[gi]);
            assign masked[gi] = hit[gi] ? LEVEL_TABLE[gi] : 8'd0;
        end
    endgenerate

    // Codes are unique in the table, so at most one masked entry is nonzero.
    always_comb begin
        level   = 8'd0;
        invalid = ~|hit;
        for (int i = 0; i < NUM_CODES; i++) begin
            level = level | masked[i];
        end
        if (invalid) begin
            level = LEVEL_TABLE[0];
        end
    end

endmodule

// File: rtl/video_out.sv
// Burst framer: BEGIN marker, oversampled data symbols, END marker, driven as
// registered luma samples; symbols are pulled from a valid/ready source.
module video_out
    import video_levels_pkg::*;
#(
    parameter int         SYMBOL_SAMPLES = 4,
    parameter logic [7:0] IDLE_LEVEL     = IDLE_LVL,
    parameter logic [7:0] BEGIN_LEVEL    = BEGIN_LVL,
    parameter logic [7:0] END_LEVEL      = END_LVL
) (
    input  logic        clkin,
    input  logic        rst,
    video_out_if.slave  bus
);

    localparam int             CW       = $clog2(SYMBOL_SAMPLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SYMBOL_SAMPLES - 1);

    vo_state_t      state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [7:0]     td_reg, td_next;
    logic           strobe_reg, strobe_next;
    logic           err_reg, err_next;

    logic           last_cycle;
    logic           ready;
    logic           transfer;
    logic [7:0]     enc_level;
    logic           enc_invalid;

    video_level_enc u_enc (
        .code    (bus.data_in),
        .level   (enc_level),
        .invalid (enc_invalid)
    );

    // Ready is a pure decode of registered state so the source never sees a
    // combinational path from its own valid.
    assign last_cycle = (cnt_reg == CNT_LAST);
    assign ready      = ((state_reg == ST_BEGIN) || (state_reg == ST_DATA)) && last_cycle;
    assign transfer   = ready && bus.data_valid;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            td_reg     <= IDLE_LEVEL;
            strobe_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            td_reg     <= td_next;
            strobe_reg <= strobe_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CW'(1);
        td_next     = td_reg;
        strobe_next = 1'b0;
        err_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                td_next  = IDLE_LEVEL;
                if (bus.data_valid) begin
                    state_next  = ST_BEGIN;
                    td_next     = BEGIN_LEVEL;
                    strobe_next = 1'b1;
                end
            end
            ST_BEGIN, ST_DATA: begin
                if (last_cycle) begin
                    cnt_next    = '0;
                    strobe_next = 1'b1;
                    if (transfer) begin
                        state_next = ST_DATA;
                        td_next    = enc_level;
                        err_next   = enc_invalid;
                    end else begin
                        state_next = ST_END;
                        td_next    = END_LEVEL;
                    end
                end
            end
            ST_END: begin
                // Valid on the exit edge is deliberately not looked at here.
                if (last_cycle) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    td_next    = IDLE_LEVEL;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                td_next    = IDLE_LEVEL;
            end
        endcase
    end

    assign bus.data_ready    = ready;
    assign bus.td_out        = td_reg;
    assign bus.sample_strobe = strobe_reg;
    assign bus.busy          = (state_reg != ST_IDLE);
    assign bus.code_err      = err_reg;

endmodule
